// File: rtl/mul4_pkg.sv
// mul4_pkg: shared definitions for the multiplier accumulation stage.
//   state_t       - control state of mul4_accum (IDLE / ACC / HOLD)
//   N_TERMS_DEF   - default maximum number of products per group
//   ACC_W_DEF     - default accumulator / result width
//   PROD_W        - width of one multiplier product
package mul4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int N_TERMS_DEF = 4;
    localparam int ACC_W_DEF   = 16;
    localparam int PROD_W      = 8;

endpackage

// File: rtl/mul4_accum.sv
// mul4_accum: sums groups of unsigned 8-bit multiplier products.
// A group opens on the first accepted product and closes on in_last or
// after N_TERMS products. The finished sum is held with its term count
// and a sticky overflow flag until the consumer takes it.
// Ports:
//   clk, rst_n         - rising-edge clock, asynchronous active-low reset
//   clear              - synchronous abort of the group and any held result
//   in_valid/in_ready  - product handshake; in_data is the product,
//                        in_last closes the group
//   out_valid/out_ready- result handshake; out_data is the group sum,
//                        out_count the number of products, out_ovf the
//                        overflow flag
module mul4_accum
    import mul4_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [PROD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    output logic [ACC_W-1:0]   out_data,
    output logic [7:0]         out_count,
    output logic               out_ovf,
    input  logic               out_ready
);

    localparam logic [7:0] N_LAST = 8'(N_TERMS);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic             accept;
    logic [ACC_W:0]   sum;
    logic [7:0]       cnt_inc;

    // One extra bit so the carry out of the accumulator is visible.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
        return {1'b0, a} + (ACC_W+1)'(b);
    endfunction

    // Both outputs decode from state only, so in_valid never reaches
    // in_ready and out_ready never reaches out_valid combinationally.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    assign accept  = in_valid & in_ready;
    assign sum     = acc_add(acc, in_data);
    assign cnt_inc = cnt + 8'd1;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_nxt   = ACC_W'(in_data);
                        cnt_nxt   = 8'd1;
                        ovf_nxt   = 1'b0;
                        state_nxt = (in_last || N_LAST == 8'd1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_nxt   = sum[ACC_W-1:0];
                        ovf_nxt   = ovf | sum[ACC_W];
                        cnt_nxt   = cnt_inc;
                        state_nxt = (in_last || cnt_inc == N_LAST) ? HOLD : ACC;
                    end
                end
                HOLD: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mul4_accum.sv
// tb_mul4_accum: directed bench for mul4_accum with a 16-bit/4-term
// instance and an 8-bit/3-term instance for wrap-around behaviour.
module tb_mul4_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_assert = 0;
    int          n_fail   = 0;

    // 16-bit accumulator, 4 terms
    logic        clear, in_valid, in_last, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    // 8-bit accumulator, 3 terms
    logic        clear8, in_valid8, in_last8, out_ready8;
    logic [7:0]  in_data8;
    logic        in_ready8, out_valid8, out_ovf8;
    logic [7:0]  out_data8;
    logic [7:0]  out_count8;

    always #5 clk = ~clk;

    mul4_accum #(.N_TERMS(4), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf), .out_ready(out_ready)
    );

    mul4_accum #(.N_TERMS(3), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear8),
        .in_valid(in_valid8), .in_data(in_data8), .in_last(in_last8),
        .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
        .out_count(out_count8), .out_ovf(out_ovf8), .out_ready(out_ready8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic last);
        in_valid8 = 1'b1; in_data8 = d; in_last8 = last;
        step();
        in_valid8 = 1'b0; in_last8 = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        clear8 = 0; in_valid8 = 0; in_data8 = 0; in_last8 = 0; out_ready8 = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a group
        send(8'h10, 0);
        send(8'h20, 0);
        chk("mid_acc_partial", out_data, 16'h0030);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_count", out_count, 0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1; in_data = 8'h01;
        step(); step(); step(); step();
        in_valid = 0;
        chk("ones_valid", out_valid, 1);
        chk("ones_data", out_data, 16'h0004);
        chk("ones_count", out_count, 4);
        chk("ones_in_ready", in_ready, 0);
        take();
        chk("ones_after_hs_valid", out_valid, 0);
        chk("ones_after_hs_ready", in_ready, 1);

        // Full group closed by count
        send(8'h0F, 0);
        send(8'hE1, 0);
        send(8'h31, 0);
        chk("full_not_yet_valid", out_valid, 0);
        send(8'h40, 0);
        chk("full_valid", out_valid, 1);
        chk("full_data", out_data, 16'h0161);
        chk("full_count", out_count, 4);
        chk("full_ovf", out_ovf, 0);
        take();

        // in_last without in_valid does nothing
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        chk("lone_last_valid", out_valid, 0);

        // Early close by in_last, then backpressure
        send(8'h24, 0);
        send(8'h09, 1);
        chk("early_valid", out_valid, 1);
        chk("early_data", out_data, 16'h002D);
        chk("early_count", out_count, 2);
        in_valid = 1; in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_data", out_data, 16'h002D);
            chk("bp_count", out_count, 2);
        end
        in_valid = 0;
        take();
        chk("bp_after_hs_ready", in_ready, 1);
        chk("bp_after_hs_valid", out_valid, 0);
        send(8'h03, 1);
        chk("bp_no_accept_data", out_data, 16'h0003);
        chk("bp_no_accept_count", out_count, 1);
        take();

        // clear during ACC with a simultaneous offer
        send(8'h40, 0);
        clear = 1; in_valid = 1; in_data = 8'h10;
        step();
        clear = 0; in_valid = 0;
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_data", out_data, 0);
        chk("clr_count", out_count, 0);
        send(8'h02, 1);
        chk("clr_next_valid", out_valid, 1);
        chk("clr_next_data", out_data, 16'h0002);
        chk("clr_next_count", out_count, 1);
        take();

        // Overflow on the 8-bit instance
        send8(8'hE1, 0);
        send8(8'h31, 0);
        chk("ovf_not_yet_valid", out_valid8, 0);
        send8(8'h01, 0);
        chk("ovf_valid", out_valid8, 1);
        chk("ovf_data", out_data8, 8'h13);
        chk("ovf_count", out_count8, 3);
        chk("ovf_flag", out_ovf8, 1);
        out_ready8 = 1; step(); out_ready8 = 0;
        send8(8'h05, 1);
        chk("ovf_next_data", out_data8, 8'h05);
        chk("ovf_next_flag", out_ovf8, 0);
        chk("ovf_next_count", out_count8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
